rob_brq: RTL

//  Branch resolution queue. Tracks in-flight branches from dispatch to retire and drives the

---
 rtl/rob_brq_pkg.sv | 18 +
 rtl/rob_brq_if.sv | 34 +++
 rtl/rob_brq_entry.sv | 44 ++++
 rtl/rob_brq.sv | 83 ++++++++
 4 files changed

// File: rtl/rob_brq_pkg.sv
// Shared types and constants for the branch resolution queue.
package rob_brq_pkg;
    localparam int BPTAG_W      = 16;
    localparam int BRQ_DEPTH    = 16;
    localparam int BRQ_IDX_W    = 4;
    // Predictor tag layout: {pht_data[1:0], pht_idx[13:0]}
    localparam int PHT_DATA_LSB = 14;
    localparam int PHT_DATA_W   = 2;
    localparam int PHT_IDX_LSB  = 0;
    localparam int PHT_IDX_W    = 14;

    typedef logic [BPTAG_W-1:0] bptag_t;

    typedef struct packed {
        bptag_t tag;
        logic   pred;
    } brq_alloc_t;
endpackage

// File: rtl/rob_brq_if.sv
// Dispatch / branch-unit / ROB / predictor-update signals of the branch queue.
import rob_brq_pkg::*;

interface rob_brq_if #(parameter int IDX_W = BRQ_IDX_W);
    logic             alloc_req;
    bptag_t           alloc_bptag;
    logic             alloc_bptaken;
    logic             brq_alloc_ready;
    logic [IDX_W-1:0] brq_alloc_idx;
    logic             br_res_valid;
    logic [IDX_W-1:0] br_res_idx;
    logic             br_res_taken;
    logic             ret_req;
    logic             brq_ret_ready;
    logic             ext_flush;
    logic             rob_ret_branch;
    bptag_t           rob_ret_bptag;
    logic             rob_ret_bptaken;
    logic             rob_flush;

    modport slave (
        input  alloc_req, alloc_bptag, alloc_bptaken, br_res_valid, br_res_idx,
               br_res_taken, ret_req, ext_flush,
        output brq_alloc_ready, brq_alloc_idx, brq_ret_ready, rob_ret_branch,
               rob_ret_bptag, rob_ret_bptaken, rob_flush
    );

    modport master (
        output alloc_req, alloc_bptag, alloc_bptaken, br_res_valid, br_res_idx,
               br_res_taken, ret_req, ext_flush,
        input  brq_alloc_ready, brq_alloc_idx, brq_ret_ready, rob_ret_branch,
               rob_ret_bptag, rob_ret_bptaken, rob_flush
    );
endinterface

// File: rtl/rob_brq_entry.sv
// One branch queue slot: valid/resolved state plus tag, predicted and actual direction.
import rob_brq_pkg::*;

module brq_entry (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       alloc_we,
    input  brq_alloc_t alloc_data,
    input  logic       res_we,
    input  logic       res_taken,
    input  logic       ret_clr,
    output logic       valid,
    output logic       resolved,
    output logic       pred,
    output logic       taken,
    output bptag_t     tag
);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            resolved <= 1'b0;
            pred     <= 1'b0;
            taken    <= 1'b0;
            tag      <= '0;
        end else if (clr) begin
            valid    <= 1'b0;
            resolved <= 1'b0;
        end else if (alloc_we) begin
            valid    <= 1'b1;
            resolved <= 1'b0;
            pred     <= alloc_data.pred;
            taken    <= 1'b0;
            tag      <= alloc_data.tag;
        end else if (ret_clr) begin
            valid    <= 1'b0;
            resolved <= 1'b0;
        end else if (res_we && valid) begin
            // stale resolves to empty slots are dropped here
            resolved <= 1'b1;
            taken    <= res_taken;
        end
    end
endmodule

// File: rtl/rob_brq.sv
// Branch resolution queue: program-ordered branch slots, retire-time predictor update and flush.
import rob_brq_pkg::*;

module rob_brq #(
    parameter int DEPTH = BRQ_DEPTH,
    parameter int IDX_W = BRQ_IDX_W
) (
    input logic      clk,
    input logic      rst,
    rob_brq_if.slave bus
);
    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

    logic [IDX_W:0]   head, tail, count;
    logic [IDX_W-1:0] head_idx, tail_idx;
    logic [DEPTH-1:0] valid, resolved, pred, taken;
    logic [DEPTH-1:0][BPTAG_W-1:0] tags;
    logic alloc_ok, ret_ok, mispred, clear_all;
    brq_alloc_t alloc_data;

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];

    // readiness is from registered state only; a same-cycle retire frees nothing
    assign bus.brq_alloc_ready = (count != FULL);
    assign bus.brq_alloc_idx   = tail_idx;
    assign bus.brq_ret_ready   = valid[head_idx] & resolved[head_idx];

    assign alloc_ok   = bus.alloc_req & bus.brq_alloc_ready;
    assign ret_ok     = bus.ret_req & bus.brq_ret_ready;
    assign mispred    = ret_ok & (pred[head_idx] != taken[head_idx]);
    assign clear_all  = mispred | bus.ext_flush;
    assign alloc_data = '{tag: bus.alloc_bptag, pred: bus.alloc_bptaken};

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        brq_entry u_entry (
            .clk       (clk),
            .rst       (rst),
            .clr       (clear_all),
            .alloc_we  (alloc_ok && tail_idx == IDX_W'(g)),
            .alloc_data(alloc_data),
            .res_we    (bus.br_res_valid && bus.br_res_idx == IDX_W'(g)),
            .res_taken (bus.br_res_taken),
            .ret_clr   (ret_ok && head_idx == IDX_W'(g)),
            .valid     (valid[g]),
            .resolved  (resolved[g]),
            .pred      (pred[g]),
            .taken     (taken[g]),
            .tag       (tags[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head <= head + (IDX_W+1)'(ret_ok);
            tail <= tail + (IDX_W+1)'(alloc_ok);
            case ({alloc_ok, ret_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // a retire accepted alongside ext_flush still reports to the predictor
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rob_ret_branch  <= 1'b0;
            bus.rob_ret_bptag   <= '0;
            bus.rob_ret_bptaken <= 1'b0;
            bus.rob_flush       <= 1'b0;
        end else begin
            bus.rob_ret_branch  <= ret_ok;
            bus.rob_ret_bptag   <= ret_ok ? tags[head_idx] : '0;
            bus.rob_ret_bptaken <= ret_ok & taken[head_idx];
            bus.rob_flush       <= clear_all;
        end
    end
endmodule
